// File: rtl/wb_sram_bridge.sv
// Wishbone classic slave bridging to a request/done SRAM back-end port.
// Optional back-end watchdog enabled by defining WB_SRAM_TIMEOUT_EN.
module wb_sram_bridge #(
    parameter int unsigned       DATA_W      = 32,
    parameter int unsigned       ADDR_W      = 32,
    parameter int unsigned       SRAM_AW     = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int unsigned       TIMEOUT_CYC = 255
) (
    input  logic                CLK_I,
    input  logic                RST_I,
    input  logic [ADDR_W-1:0]   ADR_O,
    input  logic [DATA_W-1:0]   DAT_O,
    input  logic [DATA_W/8-1:0] SEL_O,
    input  logic                WE_O,
    input  logic                STB_O,
    input  logic                CYC_O,
    output logic [DATA_W-1:0]   DAT_I,
    output logic                ACK_I,
    output logic                ERR_I,
    output logic [SRAM_AW-1:0]  s_addr,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W/8-1:0] s_be,
    output logic                s_we,
    output logic                s_req,
    input  logic [DATA_W-1:0]   s_rdata,
    input  logic                s_done
);

    localparam int unsigned BE_W = DATA_W / 8;
    localparam int unsigned LSB  = $clog2(BE_W);
    // Bits above the SRAM window must match BASE_ADDR.
    localparam logic [ADDR_W-1:0] WIN_MASK = {ADDR_W{1'b1}} << (SRAM_AW + LSB);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    if ((DATA_W % 8) != 0 || DATA_W < 8 || DATA_W > 64) begin : g_bad_data_w
        $error("wb_sram_bridge: DATA_W must be a multiple of 8 in 8..64");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("wb_sram_bridge: TIMEOUT_CYC must be at least 1");
    end

    logic [1:0]         state_q, state_d;
    logic               ack_q, ack_d;
    logic               err_q, err_d;
    logic [DATA_W-1:0]  dat_q, dat_d;
    logic               req_q, req_d;
    logic               we_q, we_d;
    logic [BE_W-1:0]    be_q, be_d;
    logic [SRAM_AW-1:0] addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic               win_hit;

`ifdef WB_SRAM_TIMEOUT_EN
    localparam int unsigned TO_RAW = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned TO_W   = (TO_RAW < 8) ? 8 : ((TO_RAW > 32) ? 32 : TO_RAW);
    logic [TO_W-1:0] cnt_q, cnt_d;
`endif

    assign win_hit = ((ADR_O ^ BASE_ADDR) & WIN_MASK) == '0;

    always_comb begin
        state_d = state_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        dat_d   = '0;
        req_d   = req_q;
        we_d    = we_q;
        be_d    = be_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
`ifdef WB_SRAM_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (STB_O && CYC_O) begin
                    if (!win_hit) begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end else if (WE_O && SEL_O == '0) begin
                        ack_d   = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        addr_d  = ADR_O[SRAM_AW+LSB-1:LSB];
                        wdata_d = DAT_O;
                        be_d    = WE_O ? SEL_O : {BE_W{1'b1}};
                        we_d    = WE_O;
                        req_d   = 1'b1;
                        state_d = ST_REQ;
`ifdef WB_SRAM_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end
                end
            end
            ST_REQ: begin
                if (s_done) begin
                    req_d = 1'b0;
                    // A dropped CYC_O is an abort: the back-end finishes silently.
                    if (CYC_O) begin
                        ack_d   = 1'b1;
                        dat_d   = we_q ? '0 : s_rdata;
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
`ifdef WB_SRAM_TIMEOUT_EN
                else if (cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
                    req_d   = 1'b0;
                    err_d   = CYC_O;
                    state_d = CYC_O ? ST_RESP : ST_IDLE;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
`endif
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_q <= ST_IDLE;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            be_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
`ifdef WB_SRAM_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            dat_q   <= dat_d;
            req_q   <= req_d;
            we_q    <= we_d;
            be_q    <= be_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
`ifdef WB_SRAM_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign DAT_I   = dat_q;
    assign ACK_I   = ack_q;
    assign ERR_I   = err_q;
    assign s_addr  = addr_q;
    assign s_wdata = wdata_q;
    assign s_be    = be_q;
    assign s_we    = we_q;
    assign s_req   = req_q;

endmodule

// File: tb/tb_wb_sram_bridge.sv
// Scoreboard bench for wb_sram_bridge: stimulus queues expected terminations,
// a monitor process pops and compares them whenever ACK_I or ERR_I is seen.
module tb_wb_sram_bridge;

    localparam int unsigned TOC = 8;

    logic        CLK_I = 1'b0;
    logic        RST_I;
    logic [31:0] ADR_O, DAT_O, DAT_I, s_wdata, s_rdata;
    logic [3:0]  SEL_O, s_be;
    logic        WE_O, STB_O, CYC_O, ACK_I, ERR_I, s_we, s_req, s_done;
    logic [15:0] s_addr;

    always #5 CLK_I = ~CLK_I;

    wb_sram_bridge #(
        .DATA_W     (32),
        .ADDR_W     (32),
        .SRAM_AW    (16),
        .BASE_ADDR  (32'h8000_0000),
        .TIMEOUT_CYC(TOC)
    ) dut (
        .CLK_I  (CLK_I),
        .RST_I  (RST_I),
        .ADR_O  (ADR_O),
        .DAT_O  (DAT_O),
        .SEL_O  (SEL_O),
        .WE_O   (WE_O),
        .STB_O  (STB_O),
        .CYC_O  (CYC_O),
        .DAT_I  (DAT_I),
        .ACK_I  (ACK_I),
        .ERR_I  (ERR_I),
        .s_addr (s_addr),
        .s_wdata(s_wdata),
        .s_be   (s_be),
        .s_we   (s_we),
        .s_req  (s_req),
        .s_rdata(s_rdata),
        .s_done (s_done)
    );

    typedef struct {
        logic        err;
        logic [31:0] dat;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          be_delay = 0;
    bit          be_en = 1'b1;
    bit          stray = 1'b0;
    logic [31:0] be_rdata = '0;

    function automatic void check(input string nm, input logic [63:0] act,
                                  input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", nm, act, req);
        end
    endfunction

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge CLK_I);
            if (ACK_I === 1'b1 || ERR_I === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_term: ack=%b err=%b, want none", ACK_I, ERR_I);
                end else begin
                    e = exp_q.pop_front();
                    check("term_err", ERR_I, e.err);
                    check("term_ack", ACK_I, !e.err);
                    check("term_dat", DAT_I, e.dat);
                end
            end
        end
    endtask

    // Back-end model: completes a request be_delay cycles after seeing s_req.
    task automatic backend();
        int cnt = 0;
        forever begin
            @(posedge CLK_I);
            #1;
            s_done = 1'b0;
            if (stray) begin
                s_done  = 1'b1;
                s_rdata = 32'h5151_5151;
                stray   = 1'b0;
            end else if (s_req && be_en) begin
                if (cnt >= be_delay) begin
                    s_done  = 1'b1;
                    s_rdata = be_rdata;
                    cnt     = 0;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    endtask

    task automatic access(input string nm, input logic [31:0] adr, input logic [31:0] wd,
                          input logic [3:0] sel, input bit we, input bit exp_req,
                          input bit exp_err, input logic [31:0] exp_dat, input int exp_lat,
                          input logic [15:0] exp_saddr, input logic [3:0] exp_be);
        int lat = 0;
        bit seen_req = 1'b0;
        bit done = 1'b0;
        exp_q.push_back('{err: exp_err, dat: exp_dat});
        @(posedge CLK_I);
        #1;
        ADR_O = adr; DAT_O = wd; SEL_O = sel; WE_O = we; STB_O = 1'b1; CYC_O = 1'b1;
        while (!done && lat < 40) begin
            @(posedge CLK_I);
            #1;
            lat++;
            if (s_req && !seen_req) begin
                seen_req = 1'b1;
                check({nm, "_saddr"}, s_addr, exp_saddr);
                check({nm, "_sbe"}, s_be, exp_be);
                check({nm, "_swdata"}, s_wdata, wd);
                check({nm, "_swe"}, s_we, we);
            end
            if (ACK_I || ERR_I) done = 1'b1;
        end
        STB_O = 1'b0; CYC_O = 1'b0;
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: got no termination in 40 cycles, want one", nm);
        end
        check({nm, "_lat"}, lat, exp_lat);
        check({nm, "_req_seen"}, seen_req, exp_req);
        check({nm, "_req_in_resp"}, s_req, 1'b0);
        @(posedge CLK_I);
        #1;
        check({nm, "_after"}, {ACK_I, ERR_I, DAT_I}, 34'h0);
    endtask

    initial begin
        int held;
        RST_I = 1'b1;
        ADR_O = '0; DAT_O = '0; SEL_O = '0; WE_O = 1'b0; STB_O = 1'b0; CYC_O = 1'b0;
        s_done = 1'b0; s_rdata = '0;
        fork
            monitor();
            backend();
        join_none
        repeat (3) @(posedge CLK_I);
        #1;
        check("rst_term", {ACK_I, ERR_I, DAT_I}, 34'h0);
        check("rst_sreq", {s_req, s_we, s_be}, 6'h0);
        check("rst_sfields", {s_addr, s_wdata}, 48'h0);
        RST_I = 1'b0;

        be_delay = 3;
        access("wr", 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 1'b1, 1'b1, 1'b0, 32'h0, 5,
               16'h0004, 4'hF);
        be_delay = 0; be_rdata = 32'hCAFE_F00D;
        access("rd", 32'h8000_0010, 32'h0, 4'hF, 1'b0, 1'b1, 1'b0, 32'hCAFE_F00D, 2,
               16'h0004, 4'hF);
        be_delay = 1;
        access("bytewr", 32'h8000_0010, 32'h00AB_0000, 4'h4, 1'b1, 1'b1, 1'b0, 32'h0, 3,
               16'h0004, 4'h4);
        access("sel0wr", 32'h8000_0010, 32'h1111_2222, 4'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1,
               16'h0, 4'h0);
        be_delay = 2; be_rdata = 32'h1234_5678;
        access("toprd", 32'h8003_FFFC, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0, 32'h1234_5678, 4,
               16'hFFFF, 4'hF);
        access("miss_lo", 32'h0000_0010, 32'h0, 4'hF, 1'b0, 1'b0, 1'b1, 32'h0, 1,
               16'h0, 4'h0);
        access("miss_hi", 32'h8004_0000, 32'h5, 4'hF, 1'b1, 1'b0, 1'b1, 32'h0, 1,
               16'h0, 4'h0);

        // Abort: CYC_O dropped while the back-end is still busy.
        be_delay = 3;
        @(posedge CLK_I);
        #1;
        ADR_O = 32'h8000_0020; DAT_O = 32'h7777_7777; SEL_O = 4'hF; WE_O = 1'b1;
        STB_O = 1'b1; CYC_O = 1'b1;
        @(posedge CLK_I);
        #1;
        check("abort_req_up", s_req, 1'b1);
        STB_O = 1'b0; CYC_O = 1'b0;
        held = 0;
        for (int i = 0; i < 20 && s_req; i++) begin
            @(posedge CLK_I);
            #1;
            if (s_req) held++;
        end
        check("abort_req_held", held, 3);
        repeat (3) @(posedge CLK_I);
        #1;
        check("abort_idle", {s_req, ACK_I, ERR_I}, 3'b000);

        // Asynchronous reset while a read waits on the back-end.
        be_en = 1'b0;
        @(posedge CLK_I);
        #1;
        ADR_O = 32'h8000_0030; DAT_O = 32'hA5A5_A5A5; SEL_O = 4'h3; WE_O = 1'b0;
        STB_O = 1'b1; CYC_O = 1'b1;
        repeat (2) @(posedge CLK_I);
        #1;
        check("rstmid_req_up", {s_req, s_addr}, {1'b1, 16'h000C});
        #2 RST_I = 1'b1;
        #1;
        check("rstmid_sreq", {s_req, s_we, s_be}, 6'h0);
        check("rstmid_sfields", {s_addr, s_wdata}, 48'h0);
        check("rstmid_term", {ACK_I, ERR_I, DAT_I}, 34'h0);
        STB_O = 1'b0; CYC_O = 1'b0;
        @(posedge CLK_I);
        #1;
        RST_I = 1'b0;

`ifdef WB_SRAM_TIMEOUT_EN
        access("wdog", 32'h8000_0040, 32'h0, 4'hF, 1'b0, 1'b1, 1'b1, 32'h0, 1 + TOC,
               16'h0010, 4'hF);
        stray = 1'b1;
        repeat (3) @(posedge CLK_I);
        #1;
        check("stray_done", {s_req, ACK_I, ERR_I}, 3'b000);
`endif
        be_en = 1'b1; be_delay = 0; be_rdata = 32'h0BAD_CAFE;
        access("final_rd", 32'h8000_0044, 32'h0, 4'hF, 1'b0, 1'b1, 1'b0, 32'h0BAD_CAFE, 2,
               16'h0011, 4'hF);

        repeat (2) @(posedge CLK_I);
        #1;
        check("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_sram_bridge.md
# wb_sram_bridge

Parametrised Wishbone classic-cycle slave that bridges a single Wishbone master to a request/done SRAM back-end port. It supersedes the fixed 32-bit, write-finish-only slave with four additions: configurable data and address widths, byte-lane selects, an address-window decode with error response, and a symmetric request/done handshake for both reads and writes. An optional watchdog turns a hung back-end into a bus error. It sits between the Wishbone interconnect and the SRAM controller FSM.

## Interface
- DATA_W, 32: Wishbone and SRAM data width; must be a multiple of 8, in the range 8..64.
- ADDR_W, 32: Wishbone byte-address width.
- SRAM_AW, 16: SRAM word-address width.
- BASE_ADDR, 32'h0000_0000: window base; aligned to a window of 2^(SRAM_AW+LSB) bytes, where LSB = log2(DATA_W/8).
- TIMEOUT_CYC, 255: cycles in REQ before error; only used with the watchdog macro; must be ≥1.

Ports:
- CLK_I  in  1  clock; all logic on rising edge.
- RST_I  in  1  asynchronous, active-high reset.
- ADR_O  in  ADDR_W  master byte address.
- DAT_O  in  DATA_W  master write data.
- SEL_O  in  DATA_W/8  byte-lane selects.
- WE_O  in  1  1 = write.
- STB_O  in  1  strobe.
- CYC_O  in  1  cycle valid.
- DAT_I  out  DATA_W  registered read data; 0 when not acking.
- ACK_I  out  1  normal termination, one-cycle pulse.
- ERR_I  out  1  error termination, one-cycle pulse.
- s_addr  out  SRAM_AW  SRAM word address = ADR_O[SRAM_AW+LSB-1:LSB].
- s_wdata  out  DATA_W  write data.
- s_be  out  DATA_W/8  byte enables; all ones for reads.
- s_we  out  1  write request.
- s_req  out  1  access request; level, held until s_done.
- s_rdata  in  DATA_W  read data; valid in the s_done cycle.
- s_done  in  1  back-end completion, one-cycle pulse.

## Operation
- State machine has three states: IDLE, REQ, RESP.
- **IDLE:** when STB_O&CYC_O is sampled high:
  - Window hit: ADR_O[ADDR_W-1:SRAM_AW+LSB] == BASE_ADDR's same bits.
  - Miss: go to RESP with ERR_I=1. No s_req.
  - Hit, write with SEL_O==0: go to RESP with ACK_I=1. No s_req.
  - Otherwise: latch s_addr, s_wdata, s_be, s_we, set s_req=1, go to REQ.
- **REQ:** s_req and the latched fields are held stable.
  - On s_done: s_req=0. Reads capture s_rdata into DAT_I.
  - If CYC_O is still high: go to RESP with ACK_I=1.
  - If CYC_O has dropped (abort): go to IDLE with no ACK or ERR. The back-end access still completes.
- **RESP:** ACK_I/ERR_I are high for exactly this cycle. Next state is IDLE; DAT_I clears to 0.
- Back-to-back: a master holding STB_O across RESP is sampled in IDLE and starts a new cycle. Minimum spacing is therefore 3 cycles per access.
- s_done outside REQ is ignored.
- Simultaneous s_done and watchdog expiry: s_done wins.

## Timing
- Reset values: ACK_I=0, ERR_I=0, DAT_I=0, s_req=0, s_we=0, s_be=0, s_addr=0, s_wdata=0. State = IDLE.
- Reset asserted mid-REQ drops s_req immediately (asynchronous). The back-end must tolerate this.
- STB sampled at edge N → s_req high after edge N.
- s_done sampled at edge M → ACK_I high from M to M+1.
- Latency with same-cycle s_done is 2 edges from STB sample to ACK.
- An error or SEL_O==0 write terminates 1 edge after STB sample.
- Outputs are registered; no combinational path from any input to any output.

## Configuration
- Macro: WB_SRAM_TIMEOUT_EN.
- Defined:
  - An 8..32-bit counter (sized by TIMEOUT_CYC) clears on REQ entry and increments each REQ cycle.
  - When the count reaches TIMEOUT_CYC with no s_done: s_req=0, go to RESP with ERR_I=1.
- Undefined: the counter and parameter are unused; REQ waits indefinitely for s_done.

## Test plan
- Reset, then write: ADR_O=0x10, DAT_O=0xDEADBEEF, SEL_O=0xF, s_done 3 cycles after s_req → s_addr=4, s_be=0xF, s_wdata=0xDEADBEEF, one ACK_I pulse the cycle after s_done.
- Read of 0x10 with s_rdata=0xCAFEF00D at s_done → DAT_I=0xCAFEF00D with ACK_I; DAT_I=0 the following cycle.
- Byte write: SEL_O=0x4 → s_be=0x4. Write with SEL_O=0x0 → ACK_I 1 cycle after STB, s_req never asserted.
- Out-of-window access with BASE_ADDR=0x8000_0000, ADR_O=0x0000_0010 → ERR_I pulse, no s_req, no ACK_I.
- CYC_O dropped during REQ → s_req held until s_done, then no ACK/ERR. RST_I pulsed mid-REQ → all outputs 0 asynchronously.
- With WB_SRAM_TIMEOUT_EN, TIMEOUT_CYC=8, s_done never asserted → ERR_I pulse after 8 REQ cycles, s_req=0; a later stray s_done is ignored.
